mdu_ctrl: RTL and testbench

Sequential multiply/divide controller for the pipelined MIPS core, sitting in the E stage beside the ALU. Accepts one-cycle start pulses for MULT/MULTU/DIV/DIVU, latches operands, models fixed multi-cycle latency with a busy counter, then commits the results to the HI/LO registers. Also serves MTHI/MTLO writes and drives HI/LO to the MFHI/MFLO result mux. Its `stallReq` output feeds the hazard unit so D-stage multiply/divide instructions stall while the unit is occupied.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_if.sv | 25 ++
 rtl/mdu_arith.sv | 54 +++++
 rtl/mdu_ctrl.sv | 104 ++++++++++
 tb/tb_mdu_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op encodings, default latencies, op helpers.
// Combinational helpers only; no state and no flow control.
package mdu_pkg;

    localparam int MD_OP_W          = 4;
    localparam int MULT_CYCLES_DEF  = 5;
    localparam int DIV_CYCLES_DEF   = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic isMul(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic isMdCalc(input logic [MD_OP_W-1:0] op);
        return isMul(op) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
// The unit never backpressures; the hazard unit uses stallReq to hold D-stage issue.
interface mdu_if;
    import mdu_pkg::*;

    logic                start;
    logic [MD_OP_W-1:0]  mdOp;
    logic [31:0]         rsData;
    logic [31:0]         rtData;
    logic                busy;
    logic                stallReq;
    logic [31:0]         hiOut;
    logic [31:0]         loOut;

    modport master (
        output start, mdOp, rsData, rtData,
        input  busy, stallReq, hiOut, loOut
    );

    modport slave (
        input  start, mdOp, rsData, rtData,
        output busy, stallReq, hiOut, loOut
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath on the latched operands; zero latency.
// divZero_o tells the controller to leave HI/LO untouched on commit.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [MD_OP_W-1:0] opR_i,
    input  logic [31:0]        aR_i,
    input  logic [31:0]        bR_i,
    output logic [31:0]        hiNext_o,
    output logic [31:0]        loNext_o,
    output logic               divZero_o
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        b_safe;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic               is_div;

    assign prod_s = {{32{aR_i[31]}}, aR_i} * {{32{bR_i[31]}}, bR_i};
    assign prod_u = {32'd0, aR_i} * {32'd0, bR_i};

    // A zero divisor is replaced so the dividers never see x; the result is discarded anyway.
    assign b_safe = (bR_i == 32'd0) ? 32'd1 : bR_i;
    assign quot_s = $signed(aR_i) / $signed(b_safe);
    assign rem_s  = $signed(aR_i) % $signed(b_safe);
    assign quot_u = aR_i / b_safe;
    assign rem_u  = aR_i % b_safe;

    assign is_div    = (opR_i == MD_DIV) || (opR_i == MD_DIVU);
    assign divZero_o = is_div && (bR_i == 32'd0);

    always_comb begin
        hiNext_o = 32'd0;
        loNext_o = 32'd0;
        case (opR_i)
            MD_MULT:  {hiNext_o, loNext_o} = prod_s;
            MD_MULTU: {hiNext_o, loNext_o} = prod_u;
            MD_DIV: begin
                hiNext_o = rem_s;
                loNext_o = quot_s;
            end
            MD_DIVU: begin
                hiNext_o = rem_u;
                loNext_o = quot_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV controller owning HI/LO; result lands MULT_CYCLES/DIV_CYCLES after issue.
// No backpressure: starts during RUN are dropped, and stallReq keeps the hazard unit from issuing them.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic   clk,
    input  logic   reset_n,
    mdu_if.slave   md
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    md_state_e          state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [MD_OP_W-1:0] opR_q, opR_d;
    logic [31:0]        aR_q, aR_d;
    logic [31:0]        bR_q, bR_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [31:0]        hiNext;
    logic [31:0]        loNext;
    logic               divZero;

    mdu_arith u_arith (
        .opR_i     (opR_q),
        .aR_i      (aR_q),
        .bR_i      (bR_q),
        .hiNext_o  (hiNext),
        .loNext_o  (loNext),
        .divZero_o (divZero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            opR_q   <= MD_NONE;
            aR_q    <= 32'd0;
            bR_q    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opR_q   <= opR_d;
            aR_q    <= aR_d;
            bR_q    <= bR_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opR_d   = opR_q;
        aR_d    = aR_q;
        bR_d    = bR_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (md.start) begin
                    if (isMdCalc(md.mdOp)) begin
                        opR_d   = md.mdOp;
                        aR_d    = md.rsData;
                        bR_d    = md.rtData;
                        cnt_d   = isMul(md.mdOp) ? MULT_CNT : DIV_CNT;
                        state_d = ST_RUN;
                    end else if (md.mdOp == MD_MTHI) begin
                        hi_d = md.rsData;
                    end else if (md.mdOp == MD_MTLO) begin
                        lo_d = md.rsData;
                    end
                end
            end
            ST_RUN: begin
                // Final busy cycle commits; <= also guards a degenerate zero-cycle parameter.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                    if (!divZero) begin
                        hi_d = hiNext;
                        lo_d = loNext;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign md.busy     = (state_q == ST_RUN);
    assign md.stallReq = md.busy | (md.start & isMdCalc(md.mdOp));
    assign md.hiOut    = hi_q;
    assign md.loOut    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a vector table of ops with expected HI/LO and busy length,
// plus hand-written sequences for reset-vs-start, ignored starts in RUN and mid-operation reset.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    mdu_if intf ();

    mdu_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op, count busy cycles while scrambling operand inputs, then check HI/LO.
    task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input int cyc, input logic [31:0] ehi, input logic [31:0] elo,
                          input string tag);
        int   n;
        logic stall_bad;
        intf.start  = 1'b1;
        intf.mdOp   = op;
        intf.rsData = rs;
        intf.rtData = rt;
        #1;
        chk({tag, " stallReq@issue"}, 32'(intf.stallReq), 32'(cyc != 0));
        chk({tag, " busy@issue"}, 32'(intf.busy), 32'd0);
        tick();
        intf.start = 1'b0;
        intf.mdOp  = MD_NONE;
        n          = 0;
        stall_bad  = 1'b0;
        while (intf.busy && n < 40) begin
            if (!intf.stallReq) stall_bad = 1'b1;
            intf.rsData = $urandom;
            intf.rtData = $urandom;
            n++;
            tick();
        end
        chk({tag, " busy cycles"}, 32'(n), 32'(cyc));
        chk({tag, " stallReq during busy"}, 32'(stall_bad), 32'd0);
        chk({tag, " hiOut"}, intf.hiOut, ehi);
        chk({tag, " loOut"}, intf.loOut, elo);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{MD_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
        vecs[3]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[4]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[6]  = '{MD_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
        vecs[7]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h10,       10, 32'h0000000F, 32'h0FFFFFFF};
        vecs[8]  = '{MD_MTHI,  32'h11111111, 32'd0,        0,  32'h11111111, 32'h0FFFFFFF};
        vecs[9]  = '{MD_MTLO,  32'h22222222, 32'd0,        0,  32'h11111111, 32'h22222222};
        vecs[10] = '{MD_DIV,   32'd5,        32'd0,        10, 32'h11111111, 32'h22222222};
        vecs[11] = '{MD_DIVU,  32'd5,        32'd0,        10, 32'h11111111, 32'h22222222};
        vecs[12] = '{4'd9,     32'h00000055, 32'd1,        0,  32'h11111111, 32'h22222222};
        vecs[13] = '{MD_MTHI,  32'hDEADBEEF, 32'd0,        0,  32'hDEADBEEF, 32'h22222222};

        // Reset held with an MTHI start: reset must win.
        reset_n     = 1'b0;
        intf.start  = 1'b1;
        intf.mdOp   = MD_MTHI;
        intf.rsData = 32'hAAAA5555;
        intf.rtData = 32'd0;
        tick();
        tick();
        chk("reset hiOut", intf.hiOut, 32'd0);
        chk("reset loOut", intf.loOut, 32'd0);
        chk("reset busy", 32'(intf.busy), 32'd0);
        intf.start = 1'b0;
        intf.mdOp  = MD_NONE;
        reset_n    = 1'b1;
        #1;
        chk("reset stallReq", 32'(intf.stallReq), 32'd0);
        tick();

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].cyc,
                   vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
        end

        // MULT with an MTLO pulse on its second busy cycle: the pulse must be dropped.
        intf.start  = 1'b1;
        intf.mdOp   = MD_MULT;
        intf.rsData = 32'h00010000;
        intf.rtData = 32'h00010000;
        tick();
        n = 0;
        while (intf.busy && n < 40) begin
            intf.start  = (n == 1);
            intf.mdOp   = (n == 1) ? MD_MTLO : MD_NONE;
            intf.rsData = 32'hCAFEBABE;
            n++;
            tick();
        end
        intf.start = 1'b0;
        intf.mdOp  = MD_NONE;
        chk("mtlo-in-run busy cycles", 32'(n), 32'd5);
        chk("mtlo-in-run hiOut", intf.hiOut, 32'h00000001);
        chk("mtlo-in-run loOut", intf.loOut, 32'h00000000);

        // Reset on the third busy cycle of a DIV discards it and clears HI/LO.
        intf.start  = 1'b1;
        intf.mdOp   = MD_DIV;
        intf.rsData = 32'd100;
        intf.rtData = 32'd7;
        tick();
        intf.start = 1'b0;
        intf.mdOp  = MD_NONE;
        tick();
        tick();
        chk("midreset busy before", 32'(intf.busy), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midreset busy", 32'(intf.busy), 32'd0);
        chk("midreset hiOut", intf.hiOut, 32'd0);
        chk("midreset loOut", intf.loOut, 32'd0);
        run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "post-reset mult");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
